// File: rtl/la_capture_reader.sv
// rtl/la_capture_reader.sv - snapshots a logic-analyzer capture array and streams it out word by word
module la_capture_reader #(
    parameter int          LA_ENTRY_LENGTH = 16,
    parameter int          LA_NUM_ENTRY    = 15,
    parameter int          HEADER_EN       = 1,
    parameter logic [7:0]  HEADER_TAG      = 8'hA5
) (
    input  logic                                         clk,
    input  logic                                         nrst,
    input  logic                                         trig_end,
    input  logic [(LA_NUM_ENTRY+1)*LA_ENTRY_LENGTH-1:0]  shift_in,
    input  logic                                         clr_ovf,
    output logic [LA_ENTRY_LENGTH-1:0]                   tx_data,
    output logic                                         tx_valid,
    input  logic                                         tx_ready,
    output logic                                         tx_last,
    output logic                                         busy,
    output logic                                         overrun
);

    localparam int NUM_WORDS = LA_NUM_ENTRY + 1;
    localparam int IW        = $clog2(NUM_WORDS + 1);
    localparam int SLOTS     = 2 ** IW;
    localparam int PADW      = SLOTS * LA_ENTRY_LENGTH;
    localparam logic [7:0] NW8 = 8'(NUM_WORDS);
    localparam logic [LA_ENTRY_LENGTH-1:0] HEADER_WORD = LA_ENTRY_LENGTH'({HEADER_TAG, NW8});

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t                       state_q;
    state_t                       state_d;
    logic                         trig_end_q;
    logic                         trig_rise;
    logic                         hdr_q;
    logic                         at_last;
    logic [IW-1:0]                idx;
    logic [PADW-1:0]              shift_pad;
    logic [LA_ENTRY_LENGTH-1:0]   snap [SLOTS];

    // Pad the capture array to a power-of-two slot count so idx can index the snapshot directly.
    assign shift_pad = PADW'(shift_in);
    assign trig_rise = trig_end & ~trig_end_q;
    assign at_last   = !hdr_q && (idx == IW'(LA_NUM_ENTRY));

    // State register; reset aborts any dump in progress.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and stream outputs; everything presented comes from registers so it holds during stalls.
    always_comb begin
        state_d  = state_q;
        tx_valid = 1'b0;
        tx_last  = 1'b0;
        tx_data  = '0;
        busy     = 1'b0;
        case (state_q)
            IDLE: begin
                if (trig_rise) begin
                    state_d = SEND;
                end
            end
            SEND: begin
                tx_valid = 1'b1;
                busy     = 1'b1;
                tx_last  = at_last;
                tx_data  = hdr_q ? HEADER_WORD : snap[idx];
                if (tx_ready && at_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Edge detect, snapshot capture, word pointer and sticky overrun flag.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            trig_end_q <= 1'b0;
            idx        <= '0;
            hdr_q      <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            trig_end_q <= trig_end;
            if (trig_rise && busy) begin
                overrun <= 1'b1;
            end else if (clr_ovf) begin
                overrun <= 1'b0;
            end
            if (state_q == IDLE && trig_rise) begin
                for (int i = 0; i < SLOTS; i++) begin
                    snap[i] <= shift_pad[i*LA_ENTRY_LENGTH +: LA_ENTRY_LENGTH];
                end
                idx   <= '0;
                hdr_q <= (HEADER_EN != 0);
            end else if (state_q == SEND && tx_ready) begin
                if (hdr_q) begin
                    hdr_q <= 1'b0;
                end else if (!at_last) begin
                    idx <= idx + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_la_capture_reader.sv
// tb/tb_la_capture_reader.sv - directed self-checking bench for la_capture_reader
module tb_la_capture_reader;

    logic          clk = 1'b0;
    logic          nrst;
    logic          trig_end;
    logic          trig2;
    logic [255:0]  shift_in;
    logic [63:0]   shift_in2;
    logic          clr_ovf;
    logic          tx_ready;
    logic [15:0]   tx_data, tx_data2;
    logic          tx_valid, tx_valid2;
    logic          tx_last, tx_last2;
    logic          busy, busy2;
    logic          overrun, overrun2;

    logic          sel;
    logic [15:0]   m_data;
    logic          m_valid, m_last, m_busy;

    int            n_assert = 0;
    int            n_fail   = 0;
    logic [15:0]   got_d [64];
    logic          got_l [64];
    int            n;

    always #5 clk = ~clk;

    la_capture_reader dut (
        .clk(clk), .nrst(nrst), .trig_end(trig_end), .shift_in(shift_in), .clr_ovf(clr_ovf),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_last(tx_last),
        .busy(busy), .overrun(overrun)
    );

    la_capture_reader #(.LA_ENTRY_LENGTH(16), .LA_NUM_ENTRY(3), .HEADER_EN(0), .HEADER_TAG(8'hA5)) dut2 (
        .clk(clk), .nrst(nrst), .trig_end(trig2), .shift_in(shift_in2), .clr_ovf(1'b0),
        .tx_data(tx_data2), .tx_valid(tx_valid2), .tx_ready(tx_ready), .tx_last(tx_last2),
        .busy(busy2), .overrun(overrun2)
    );

    assign m_data  = sel ? tx_data2  : tx_data;
    assign m_valid = sel ? tx_valid2 : tx_valid;
    assign m_last  = sel ? tx_last2  : tx_last;
    assign m_busy  = sel ? busy2     : busy;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load_default();
        for (int i = 0; i < 16; i++) shift_in[i*16 +: 16] = 16'h1000 + 16'(i);
    endtask

    task automatic fire(input bit second);
        @(negedge clk);
        chk("pre_trigger_valid", {31'd0, m_valid}, 32'd0);
        if (second) trig2 = 1'b1; else trig_end = 1'b1;
        @(posedge clk);
        #1;
        if (second) trig2 = 1'b0; else trig_end = 1'b0;
    endtask

    // mode 0: ready always high; mode 1: ready pattern 1,0,0 repeating
    task automatic dump(input int mode, input int mutate_at, input int trig_at, input int abort_at, output int cnt);
        bit          stall;
        bit          done;
        logic [15:0] pd;
        logic        pl;
        cnt = 0; stall = 0; done = 0; pd = '0; pl = 1'b0;
        for (int c = 0; c < 400 && !done; c++) begin
            @(negedge clk);
            if (c == mutate_at) shift_in = '1;
            if (trig_at >= 0 && c == trig_at) trig_end = 1'b1;
            if (trig_at >= 0 && c == trig_at + 1) trig_end = 1'b0;
            if (cnt == abort_at) begin
                nrst = 1'b0;
                done = 1;
            end else begin
                tx_ready = (mode == 0) ? 1'b1 : (c % 3 == 0);
                if (stall) begin
                    chk("hold_data", {16'd0, m_data}, {16'd0, pd});
                    chk("hold_last", {31'd0, m_last}, {31'd0, pl});
                end
                chk("valid_in_dump", {31'd0, m_valid}, 32'd1);
                if (!m_valid) begin
                    done = 1;
                end else if (tx_ready) begin
                    got_d[cnt] = m_data;
                    got_l[cnt] = m_last;
                    cnt++;
                    if (m_last || cnt >= 64) done = 1;
                end
                stall = !tx_ready;
                pd    = m_data;
                pl    = m_last;
            end
        end
        if (!done) chk("dump_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_seq(input int cnt, input int exp_n, input bit hdr, input logic [15:0] base);
        logic [15:0] e;
        chk("beat_count", cnt, exp_n);
        for (int k = 0; k < cnt && k < exp_n; k++) begin
            e = (hdr && k == 0) ? 16'hA510 : base + 16'(k - int'(hdr));
            chk("beat_data", {16'd0, got_d[k]}, {16'd0, e});
            chk("beat_last", {31'd0, got_l[k]}, (k == exp_n - 1) ? 32'd1 : 32'd0);
        end
    endtask

    task automatic check_idle();
        @(negedge clk);
        chk("idle_valid", {31'd0, m_valid}, 32'd0);
        chk("idle_last",  {31'd0, m_last},  32'd0);
        chk("idle_busy",  {31'd0, m_busy},  32'd0);
    endtask

    initial begin
        nrst = 1'b0; trig_end = 1'b0; trig2 = 1'b0; clr_ovf = 1'b0; tx_ready = 1'b0; sel = 1'b0;
        shift_in = '0;
        load_default();
        for (int i = 0; i < 4; i++) shift_in2[i*16 +: 16] = 16'h2000 + 16'(i);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid",   {31'd0, tx_valid}, 32'd0);
        chk("rst_last",    {31'd0, tx_last},  32'd0);
        chk("rst_data",    {16'd0, tx_data},  32'd0);
        chk("rst_busy",    {31'd0, busy},     32'd0);
        chk("rst_overrun", {31'd0, overrun},  32'd0);
        nrst = 1'b1;

        // basic dump
        fire(0);
        dump(0, -1, -1, -1, n);
        check_seq(n, 17, 1, 16'h1000);
        check_idle();

        // backpressure
        fire(0);
        dump(1, -1, -1, -1, n);
        check_seq(n, 17, 1, 16'h1000);
        check_idle();

        // snapshot isolation
        fire(0);
        dump(0, 1, -1, -1, n);
        check_seq(n, 17, 1, 16'h1000);
        check_idle();
        load_default();

        // overrun during a dump
        chk("ovf_before", {31'd0, overrun}, 32'd0);
        fire(0);
        dump(0, -1, 5, -1, n);
        check_seq(n, 17, 1, 16'h1000);
        check_idle();
        chk("ovf_set", {31'd0, overrun}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("no_second_dump", {31'd0, tx_valid}, 32'd0);
        end

        // held trigger: exactly one dump
        @(negedge clk);
        trig_end = 1'b1;
        @(posedge clk);
        #1;
        dump(0, -1, -1, -1, n);
        check_seq(n, 17, 1, 16'h1000);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("held_no_retrigger", {31'd0, tx_valid}, 32'd0);
        end
        trig_end = 1'b0;
        @(negedge clk);
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
        chk("ovf_cleared", {31'd0, overrun}, 32'd0);

        // reset mid-dump after the 5th handshake
        fire(0);
        dump(1, -1, 2, 5, n);
        chk("abort_beats", n, 5);
        @(posedge clk);
        #1;
        chk("abort_valid",   {31'd0, tx_valid}, 32'd0);
        chk("abort_busy",    {31'd0, busy},     32'd0);
        chk("abort_overrun", {31'd0, overrun},  32'd0);
        @(negedge clk);
        nrst = 1'b1;
        fire(0);
        dump(0, -1, -1, -1, n);
        check_seq(n, 17, 1, 16'h1000);
        check_idle();

        // no header, four entries
        sel = 1'b1;
        fire(1);
        dump(0, -1, -1, -1, n);
        check_seq(n, 4, 0, 16'h2000);
        check_idle();
        chk("dut2_overrun", {31'd0, overrun2}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/la_capture_reader.md
Name: la_capture_reader

Overview:
- Read-side companion to logic_analyzer.
- When the analyzer signals end of capture, this block snapshots the complete captured sample array and streams it out one entry per beat over a valid/ready interface.
- The stream feeds the debug/readout path: a host-facing serializer or a bench monitor.
- An optional header word precedes the samples. A sticky flag records triggers lost while a dump is in progress.

Parameters:
- LA_ENTRY_LENGTH, 16: width of one sample entry in bits. Must be >= 16.
- LA_NUM_ENTRY, 15: highest entry index. The array holds NUM_WORDS = LA_NUM_ENTRY+1 entries.
- HEADER_EN, 1: when 1, emit a header word before the samples.
- HEADER_TAG, 8'hA5: upper byte of the header word.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- nrst  input  1  reset, synchronous, active-low.
- trig_end  input  1  capture-complete indication from logic_analyzer. Level signal, may stay high for many cycles.
- shift_in  input  NUM_WORDS*LA_ENTRY_LENGTH  flattened capture array. Entry i occupies bits [i*LEN +: LEN].
- clr_ovf  input  1  clears the overrun flag.
- tx_data  output  LA_ENTRY_LENGTH  current stream word.
- tx_valid  output  1  tx_data is valid.
- tx_ready  input  1  downstream accepts the word when high together with tx_valid.
- tx_last  output  1  marks the final word of a dump.
- busy  output  1  a dump is in progress (latched or sending).
- overrun  output  1  sticky: a trig_end rising edge arrived while busy.

Behaviour:
- Reset (nrst=0 at a clk edge): tx_valid=0, tx_last=0, tx_data=0, busy=0, overrun=0, idx=0, trig_end_q=0, state=IDLE.
  - Reset mid-dump aborts the dump immediately; no partial completion.
- Edge detect:
  - trig_rise = trig_end & ~trig_end_q, with trig_end_q registered every cycle.
  - Only rising edges start dumps. A held-high trig_end never retriggers.
- States:
  - IDLE: tx_valid=0, busy=0. On trig_rise, capture all of shift_in into an internal buffer (same edge), set busy=1, idx=0, go to SEND.
    - Latency: trig_rise sampled at edge N → tx_valid=1 after edge N, i.e. first word presented in cycle N+1.
  - SEND: tx_valid=1.
    - Word k of the dump:
      - header (k=0, when HEADER_EN=1) = {HEADER_TAG, 8-bit NUM_WORDS}, zero-extended in the upper bits if LEN>16;
      - otherwise buf[idx], emitted in order entry 0 first, entry LA_NUM_ENTRY last.
    - tx_data and tx_last must stay stable while tx_valid=1 and tx_ready=0.
    - On handshake (tx_valid & tx_ready): advance to the next word. tx_valid is never deasserted between words.
    - tx_last=1 only while presenting entry LA_NUM_ENTRY.
    - Handshake on the last word → IDLE at the next edge: tx_valid=0, tx_last=0, busy=0.
    - Total beats per dump = NUM_WORDS + HEADER_EN.
- Back-to-back: a trig_rise in the same cycle as the final handshake is treated as arriving while busy. It sets overrun and does not start a dump.
- Overrun:
  - trig_rise while busy=1 sets overrun=1. The snapshot is not replaced and the dump continues unchanged.
  - clr_ovf=1 clears overrun at the next edge. If clr_ovf and a new overrun event occur in the same cycle, set wins.
- The snapshot is isolated: changes on shift_in after the capture edge never affect the words being streamed.
- idx counter width is clog2(NUM_WORDS+1). Wrap-around is impossible because SEND exits at the last index.

Test Plan:
1. Basic dump, defaults, entry i = 16'h1000+i, tx_ready=1: pulse trig_end one cycle.
   → tx_valid rises the cycle after the edge.
   → 17 consecutive beats: 16'hA510, then 16'h1000..16'h100F.
   → tx_last only on 16'h100F; busy falls the cycle after.
2. Backpressure: same stimulus, tx_ready toggles 1,0,0,1,… (pattern repeating).
   → Each word is held stable across stalls; the same 17-word sequence with no duplicates or drops.
3. Snapshot isolation: change every shift_in entry to 16'hFFFF two cycles after the trigger.
   → Stream still carries 16'h1000..16'h100F.
4. Overrun: while streaming, pulse trig_end again.
   → overrun=1, stream unchanged, no second dump.
   → Hold trig_end high for 40 cycles after IDLE: exactly one dump.
   → clr_ovf pulse → overrun=0.
5. Reset mid-dump: assert nrst=0 after the 5th handshake.
   → Next edge: tx_valid=0, busy=0, overrun=0.
   → A new trigger after release restarts from the header.
6. HEADER_EN=0, LA_NUM_ENTRY=3: trigger.
   → Exactly 4 beats, entries 0..3, tx_last on entry 3.
